// File: rtl/demux2_8b_buf.sv
// demux2_8b_buf: 1-to-2 valid/ready demultiplexer, one 8-bit
// skid-free 1-entry buffer per output, full-rate throughput.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_val     input stream valid
//   in_rdy     input stream ready (combinational)
//   in_sel     destination select (0 -> out0, 1 -> out1)
//   in_data    input payload [7:0]
//   out0_val   output 0 valid       out0_rdy  output 0 ready
//   out0_data  output 0 payload     (likewise for out1_*)
//   cnt0/cnt1  per-output transfer counters, only with DEMUX2_CNT_EN
//
// Build option: define DEMUX2_CNT_EN to add the cnt0/cnt1 counters.

module demux2_8b_buf (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_val,
   output logic       in_rdy,
   input  logic       in_sel,
   input  logic [7:0] in_data,
   output logic       out0_val,
   input  logic       out0_rdy,
   output logic [7:0] out0_data,
   output logic       out1_val,
   input  logic       out1_rdy,
   output logic [7:0] out1_data
`ifdef DEMUX2_CNT_EN
   ,
   output logic [7:0] cnt0,
   output logic [7:0] cnt1
`endif
);

   logic       full0, full1;
   logic [7:0] data0, data1;
   logic       xfer_in;
   logic       ld0, ld1;
   logic       pop0, pop1;

   // A full buffer can still accept when its consumer drains it
   // in the same cycle, giving one word per cycle per output.
   assign in_rdy  = in_sel ? (!full1 || out1_rdy)
                           : (!full0 || out0_rdy);

   assign xfer_in = in_val && in_rdy;
   assign ld0     = xfer_in && !in_sel;
   assign ld1     = xfer_in &&  in_sel;
   assign pop0    = full0 && out0_rdy;
   assign pop1    = full1 && out1_rdy;

   assign out0_val  = full0;
   assign out0_data = data0;
   assign out1_val  = full1;
   assign out1_data = data1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         full0 <= 1'b0;
         data0 <= 8'h00;
      end else if (ld0) begin
         full0 <= 1'b1;
         data0 <= in_data;
      end else if (pop0) begin
         full0 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         full1 <= 1'b0;
         data1 <= 8'h00;
      end else if (ld1) begin
         full1 <= 1'b1;
         data1 <= in_data;
      end else if (pop1) begin
         full1 <= 1'b0;
      end
   end

`ifdef DEMUX2_CNT_EN
   logic [7:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt0_q <= 8'h00;
         cnt1_q <= 8'h00;
      end else begin
         if (pop0) cnt0_q <= cnt0_q + 8'h01;
         if (pop1) cnt1_q <= cnt1_q + 8'h01;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule
